example_sdiv_21s_8s_14_seq: RTL



---
 rtl/example_sdiv_21s_8s_14_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/example_sdiv_21s_8s_14_seq.sv
// Iterative signed divider (restoring, one quotient bit per cycle, C-style truncation toward zero).
// Latency: operands accepted in the ap_ready cycle; ap_done pulses DIVIDEND_W+2 cycles later (23 for the defaults).
// Backpressure: none; ap_start is only sampled in IDLE and is never queued. Optional macro EXAMPLE_SDIV_SAT_EN saturates quot on overflow.
module example_sdiv_21s_8s_14_seq #(
    parameter int DIVIDEND_W = 21,
    parameter int DIVISOR_W  = 8,
    parameter int QUOT_W     = 14
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic signed [DIVIDEND_W-1:0] din0,
    input  logic signed [DIVISOR_W-1:0]  din1,
    output logic signed [QUOT_W-1:0]     quot,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                         ovf,
    output logic                         dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIVIDEND_W - 1);
    localparam logic [QUOT_W-1:0] QMAX     = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QMIN     = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched operand magnitudes and signs
    logic [DIVIDEND_W-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_neg_a;
    logic                  r_neg_b;
    logic                  r_zero;
    logic [CNT_W-1:0]      r_cnt;

    // Registered results
    logic [QUOT_W-1:0]     r_quot;
    logic [DIVISOR_W-1:0]  r_rem_o;
    logic                  r_ovf;
    logic                  r_dbz;

    logic                  w_accept;
    logic [DIVIDEND_W-1:0] w_a_u;
    logic [DIVISOR_W-1:0]  w_b_u;
    logic [DIVIDEND_W-1:0] w_a_abs;
    logic [DIVISOR_W-1:0]  w_b_abs;
    logic [DIVISOR_W:0]    w_trial;
    logic [DIVISOR_W+1:0]  w_diff;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic                  w_neg_q;
    logic [DIVIDEND_W:0]   w_q_s;
    logic [DIVIDEND_W:QUOT_W-1] w_q_hi;
    logic                  w_ovf;
    logic [QUOT_W-1:0]     w_q_out;

    assign w_accept = (r_state == S_IDLE) && ap_start;

    // Magnitudes: the most negative inputs still fit their unsigned widths
    assign w_a_u   = din0;
    assign w_b_u   = din1;
    assign w_a_abs = din0[DIVIDEND_W-1] ? (~w_a_u + 1'b1) : w_a_u;
    assign w_b_abs = din1[DIVISOR_W-1]  ? (~w_b_u + 1'b1) : w_b_u;

    // One restoring step: the borrow bit of the trial subtraction decides the quotient bit
    assign w_trial   = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_diff    = {1'b0, w_trial} - {2'b00, r_dvs};
    assign w_ge      = ~w_diff[DIVISOR_W+1];
    assign w_rem_nxt = w_ge ? DIVISOR_W'(w_diff) : DIVISOR_W'(w_trial);

    // Signed quotient one bit wider than the magnitude, so +2^(DIVIDEND_W-1) is representable
    assign w_neg_q = r_neg_a ^ r_neg_b;
    assign w_q_s   = w_neg_q ? (~{1'b0, r_quo} + 1'b1) : {1'b0, r_quo};
    assign w_q_hi  = w_q_s[DIVIDEND_W:QUOT_W-1];
    assign w_ovf   = ~((&w_q_hi) | ~(|w_q_hi));

`ifdef EXAMPLE_SDIV_SAT_EN
    assign w_q_out = w_ovf ? (w_neg_q ? QMIN : QMAX) : QUOT_W'(w_q_s);
`else
    assign w_q_out = QUOT_W'(w_q_s);
`endif

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == LAST_CNT) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs; reset suppresses acceptance in the same cycle
    always_comb begin
        ap_idle  = (r_state == S_IDLE);
        ap_ready = (r_state == S_IDLE) && ap_start && !ap_rst;
        ap_done  = (r_state == S_DONE);
    end

    // Operand latch, shift-subtract iterations and sign fix-up of the results
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_quo   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem_o <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quo   <= w_a_abs;
                        r_dvs   <= w_b_abs;
                        r_rem   <= '0;
                        r_neg_a <= din0[DIVIDEND_W-1];
                        r_neg_b <= din1[DIVISOR_W-1];
                        r_zero  <= (din1 == '0);
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[DIVIDEND_W-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_dbz <= r_zero;
                    if (r_zero) begin
                        // Divide by zero: iteration results are discarded
                        r_quot  <= r_neg_a ? QMIN : QMAX;
                        r_rem_o <= '0;
                        r_ovf   <= 1'b0;
                    end else begin
                        r_quot  <= w_q_out;
                        r_rem_o <= r_neg_a ? (~r_rem + 1'b1) : r_rem;
                        r_ovf   <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem_o;
    assign ovf  = r_ovf;
    assign dbz  = r_dbz;

endmodule
